ws2812_frame_scheduler: RTL and testbench

Frame-level controller that sits between the host-side pixel writer (SPI bridge) and the `ws2812` serial driver. It owns a two-bank pixel buffer: the host fills the back bank while the driver reads the front bank. Each frame the block swaps banks on a commit, or re-sends the current frame on a refresh tick, then starts the driver and tracks the frame until it completes. It also serves the driver's per-LED data requests, applying a global brightness scale.

---
 rtl/ws2812_frame_scheduler.sv | 172 +++++++++++++++++
 tb/tb_ws2812_frame_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler: two-bank pixel store with frame sequencing for a
// ws2812 serial driver. The host fills the back bank while the driver reads
// the front bank. Banks swap on a commit, the current frame is re-sent on a
// refresh tick, and a global brightness scale is applied to the driver data.
module ws2812_frame_scheduler #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned SYSTEM_CLOCK = 50000000,
  parameter int unsigned REFRESH_HZ   = 30,
  parameter int unsigned AW           = $clog2(NUM_LEDS)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [23:0]   wr_data_i,
  input  logic          commit_i,
  input  logic [AW-1:0] led_count_i,
  input  logic [7:0]    brightness_i,
  output logic          commit_pending_o,
  output logic          frame_done_o,
  output logic          drv_start_o,
  input  logic          drv_busy_i,
  input  logic          drv_data_request_i,
  input  logic [AW-1:0] drv_address_i,
  output logic [7:0]    drv_red_o,
  output logic [7:0]    drv_green_o,
  output logic [7:0]    drv_blue_o,
  output logic [AW-1:0] drv_led_count_o
);

  localparam int unsigned REFRESH_PERIOD =
    (REFRESH_HZ == 0) ? 1 : SYSTEM_CLOCK / REFRESH_HZ;

  typedef enum logic [2:0] {IDLE, SWAP, START, WAIT_BUSY, SEND} state_t;

  state_t        state, state_next;
  logic          front;
  logic [AW-1:0] shadow_led_count;
  logic [7:0]    shadow_brightness;
  logic          refresh_pending;
  logic [31:0]   refresh_cnt;
  logic          refresh_tick;
  logic          start_entry;
  logic          wr_addr_ok;
  logic          rd_addr_ok;
  logic [23:0]   bank_mem [2][NUM_LEDS];
  logic [23:0]   rd_pixel;

  // Per-channel brightness scale: (c * (b + 1)) >> 8 on a 16-bit product.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * (16'(b) + 16'd1);
    return 8'(p >> 8);
  endfunction

  assign wr_addr_ok      = (32'(wr_addr_i) < NUM_LEDS);
  assign rd_addr_ok      = (32'(drv_address_i) < NUM_LEDS);
  assign refresh_tick    = (REFRESH_HZ != 0) && (refresh_cnt == REFRESH_PERIOD - 1);
  assign start_entry     = (state != START) && (state_next == START);
  assign drv_led_count_o = shadow_led_count;
  assign rd_pixel        = rd_addr_ok ? bank_mem[front][drv_address_i] : '0;

  // Host writes always target the back bank; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_addr_ok) begin
      bank_mem[~front][wr_addr_i] <= wr_data_i;
    end
  end

  // Free-running refresh period counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      refresh_cnt <= '0;
    end else if (refresh_tick || REFRESH_HZ == 0) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  // Refresh request: a new tick wins over consumption so no tick is lost.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      refresh_pending <= 1'b0;
    end else if (refresh_tick) begin
      refresh_pending <= 1'b1;
    end else if (start_entry) begin
      refresh_pending <= 1'b0;
    end
  end

  // Commit request: merges repeated commits, cleared by the swap it causes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      commit_pending_o <= 1'b0;
    end else if (commit_i) begin
      commit_pending_o <= 1'b1;
    end else if (state == SWAP) begin
      commit_pending_o <= 1'b0;
    end
  end

  // Bank select and shadow configuration, updated only by a swap.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      front             <= 1'b0;
      shadow_led_count  <= AW'(NUM_LEDS);
      shadow_brightness <= 8'hFF;
    end else if (state == SWAP) begin
      front             <= ~front;
      shadow_led_count  <= led_count_i;
      shadow_brightness <= brightness_i;
    end
  end

  // Frame sequencer state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and strobes. IDLE also looks at commit_i directly so that the
  // swap follows the commit pulse by one cycle, in step with commit_pending_o.
  always_comb begin
    state_next   = state;
    drv_start_o  = 1'b0;
    frame_done_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit_i || commit_pending_o) begin
          state_next = SWAP;
        end else if (refresh_pending) begin
          state_next = START;
        end
      end
      SWAP: state_next = START;
      START: begin
        drv_start_o = 1'b1;
        state_next  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (drv_busy_i) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (!drv_busy_i) begin
          frame_done_o = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Scaled pixel for the driver, held until the next request.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drv_red_o   <= '0;
      drv_green_o <= '0;
      drv_blue_o  <= '0;
    end else if (drv_data_request_i) begin
      drv_red_o   <= scale_chan(rd_pixel[23:16], shadow_brightness);
      drv_green_o <= scale_chan(rd_pixel[15:8],  shadow_brightness);
      drv_blue_o  <= scale_chan(rd_pixel[7:0],   shadow_brightness);
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Testbench for ws2812_frame_scheduler: a driver model answers start pulses,
// expected pixels go into a queue, and a monitor compares each response.
// A second instance with a 1000-cycle refresh period checks re-send timing.
module tb_ws2812_frame_scheduler;
  localparam int NL = 8;
  localparam int AW = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- main instance ----------------
  logic          reset_ni, wr_en_i, commit_i, drv_busy_i, drv_data_request_i;
  logic [AW-1:0] wr_addr_i, led_count_i, drv_address_i, drv_led_count_o;
  logic [23:0]   wr_data_i;
  logic [7:0]    brightness_i, drv_red_o, drv_green_o, drv_blue_o;
  logic          commit_pending_o, frame_done_o, drv_start_o;

  ws2812_frame_scheduler #(.NUM_LEDS(NL), .SYSTEM_CLOCK(50000000), .REFRESH_HZ(0)) u_dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .commit_i(commit_i), .led_count_i(led_count_i),
    .brightness_i(brightness_i), .commit_pending_o(commit_pending_o),
    .frame_done_o(frame_done_o), .drv_start_o(drv_start_o), .drv_busy_i(drv_busy_i),
    .drv_data_request_i(drv_data_request_i), .drv_address_i(drv_address_i),
    .drv_red_o(drv_red_o), .drv_green_o(drv_green_o), .drv_blue_o(drv_blue_o),
    .drv_led_count_o(drv_led_count_o)
  );

  // ---------------- refresh instance ----------------
  logic          r_rst_n, r_wr_en, r_commit, r_busy, r_req;
  logic [AW-1:0] r_wr_addr, r_cnt, r_addr, r_led_cnt;
  logic [23:0]   r_wr_data;
  logic [7:0]    r_bright, r_red, r_green, r_blue;
  logic          r_pending, r_frame_done, r_start;
  bit            r_done = 0;

  ws2812_frame_scheduler #(.NUM_LEDS(NL), .SYSTEM_CLOCK(30000), .REFRESH_HZ(30)) u_dut_rf (
    .clk_i(clk_i), .reset_ni(r_rst_n), .wr_en_i(r_wr_en), .wr_addr_i(r_wr_addr),
    .wr_data_i(r_wr_data), .commit_i(r_commit), .led_count_i(r_cnt),
    .brightness_i(r_bright), .commit_pending_o(r_pending),
    .frame_done_o(r_frame_done), .drv_start_o(r_start), .drv_busy_i(r_busy),
    .drv_data_request_i(r_req), .drv_address_i(r_addr),
    .drv_red_o(r_red), .drv_green_o(r_green), .drv_blue_o(r_blue),
    .drv_led_count_o(r_led_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] m_bank [2][NL];
  int m_front, m_bright, m_cnt, m_nb, m_nc;
  bit m_pending;

  function automatic int sc(input int c, input int b);
    return (c * (b + 1)) / 256;
  endfunction

  function automatic logic [23:0] exp_pix(input int k);
    logic [23:0] p;
    p = m_bank[m_front][k];
    return {8'(sc(int'(p[23:16]), m_bright)), 8'(sc(int'(p[15:8]), m_bright)),
            8'(sc(int'(p[7:0]), m_bright))};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [23:0] exp_q [$];
  logic req_q = 1'b0;
  always @(posedge clk_i) req_q <= drv_data_request_i;

  always @(negedge clk_i) begin : monitor
    logic [23:0] e;
    if (req_q) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pixel: response %h with no expected value queued", {drv_red_o, drv_green_o, drv_blue_o});
      end else begin
        e = exp_q.pop_front();
        check("pixel", {8'h00, drv_red_o, drv_green_o, drv_blue_o}, {8'h00, e});
      end
    end
  end

  // ---------------- driver model ----------------
  bit hang_mode = 0, long_frame = 0, frame_active = 0, in_send = 0;
  int starts = 0, frames = 0, exp_start_cyc = -1;

  task automatic run_frame();
    int n, tail;
    n = (m_cnt == 0) ? NL : m_cnt;
    tail = long_frame ? 40 : 2;
    @(posedge clk_i); #1 drv_busy_i = 1'b1;
    @(posedge clk_i); #1 in_send = 1;
    for (int k = 0; k < n; k++) begin
      drv_data_request_i = 1'b1;
      drv_address_i = AW'(k);
      exp_q.push_back(exp_pix(k));
      @(posedge clk_i); #1 drv_data_request_i = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end
    repeat (tail) begin @(posedge clk_i); #1; end
    @(negedge clk_i); check("done_low_while_busy", 32'(frame_done_o), 0);
    @(posedge clk_i); #1 in_send = 0; drv_busy_i = 1'b0;
    @(negedge clk_i); check("frame_done", 32'(frame_done_o), 1);
    frames++;
    frame_active = 0;
    if (m_pending) exp_start_cyc = cyc + 3;
  endtask

  initial begin : driver
    drv_busy_i = 1'b0; drv_data_request_i = 1'b0; drv_address_i = '0;
    forever begin
      @(negedge clk_i);
      if (drv_start_o === 1'b1) begin
        starts++;
        if (exp_start_cyc >= 0) check("start_cycle", cyc, exp_start_cyc);
        else begin
          checks++; errors++;
          $display("FAIL start_cycle: start at cycle %0d, required none", cyc);
        end
        exp_start_cyc = -1;
        check("pending_after_swap", 32'(commit_pending_o), 0);
        m_front ^= 1; m_bright = m_nb; m_cnt = m_nc; m_pending = 0;
        check("led_count", 32'(drv_led_count_o), m_cnt);
        frame_active = 1;
        if (!hang_mode) run_frame();
      end
    end
  end

  // ---------------- host tasks ----------------
  task automatic host_write(input int a, input logic [23:0] d);
    wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_data_i = d;
    m_bank[m_front ^ 1][a] = d;
    @(posedge clk_i); #1 wr_en_i = 1'b0;
  endtask

  task automatic do_commit(input int bright, input int cnt);
    brightness_i = 8'(bright); led_count_i = AW'(cnt);
    m_nb = bright; m_nc = cnt;
    commit_i = 1'b1;
    if (!frame_active) exp_start_cyc = cyc + 2;
    else m_pending = 1;
    @(posedge clk_i); #1 commit_i = 1'b0;
    @(negedge clk_i); check("pending_set", 32'(commit_pending_o), 1);
    @(posedge clk_i); #1;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames < target && t < 3000) begin @(posedge clk_i); #1; t++; end
    check("frames_reached", 32'(frames >= target), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // ---------------- main sequence ----------------
  initial begin : seq
    int nf, t, s0;
    reset_ni = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    commit_i = 1'b0; led_count_i = '0; brightness_i = 8'hFF;
    m_front = 0; m_bright = 255; m_cnt = 0; m_nb = 255; m_nc = 0; m_pending = 0;
    nf = 0;
    @(posedge clk_i); #1;
    check("rst_outputs", {28'h0, commit_pending_o, frame_done_o, drv_start_o, 1'b0}, 0);
    check("rst_rgb", {8'h0, drv_red_o, drv_green_o, drv_blue_o}, 0);
    check("rst_led_count", 32'(drv_led_count_o), 0);
    idle(2);
    reset_ni = 1'b1;
    idle(10);
    check("idle_no_start", starts, 0);

    // Directed frame: identity brightness, incrementing blue.
    for (int i = 0; i < NL; i++) host_write(i, 24'h0A0B0C + 24'(i));
    do_commit(255, 0); nf++; wait_frames(nf); idle(3);

    // Brightness 127 on 0xFF8001.
    for (int i = 0; i < NL; i++) host_write(i, 24'hFF8001);
    do_commit(127, 0); nf++; wait_frames(nf); idle(3);

    // Randomized frames.
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < NL; i++) host_write(i, 24'($urandom));
      do_commit(int'($urandom_range(0, 255)), int'($urandom_range(0, NL - 1)));
      nf++; wait_frames(nf); idle(int'($urandom_range(1, 5)));
    end

    // Back-bank writes and two merged commits during SEND.
    for (int i = 0; i < NL; i++) host_write(i, 24'($urandom));
    long_frame = 1;
    do_commit(200, 0); nf++;
    t = 0;
    while (!in_send && t < 100) begin idle(1); t++; end
    check("reached_send", 32'(in_send), 1);
    for (int i = 0; i < NL; i++) host_write(i, 24'($urandom));
    do_commit(90, 5);
    idle(2);
    do_commit(90, 5); nf++;
    long_frame = 0;
    wait_frames(nf);
    idle(40);
    check("merged_start_count", starts, nf);

    // Reset while the driver never raises busy.
    for (int i = 0; i < NL; i++) host_write(i, 24'($urandom));
    hang_mode = 1;
    s0 = starts;
    do_commit(255, 0);
    t = 0;
    while (starts == s0 && t < 50) begin idle(1); t++; end
    idle(2);
    do_commit(255, 0);
    #2 reset_ni = 1'b0;
    #1;
    check("async_rst_start", 32'(drv_start_o), 0);
    check("async_rst_pending", 32'(commit_pending_o), 0);
    check("async_rst_done", 32'(frame_done_o), 0);
    m_front = 0; m_bright = 255; m_cnt = 0; m_nb = 255; m_nc = 0; m_pending = 0;
    frame_active = 0; exp_start_cyc = -1; hang_mode = 0;
    s0 = starts;
    idle(3);
    reset_ni = 1'b1;
    idle(50);
    check("post_rst_no_start", starts, s0);
    check("post_rst_pending", 32'(commit_pending_o), 0);

    // Frame after reset.
    frames = 0; nf = 0;
    for (int i = 0; i < NL; i++) host_write(i, 24'($urandom));
    do_commit(int'($urandom_range(0, 255)), 0); nf++; wait_frames(nf); idle(5);
    check("queue_drained", exp_q.size(), 0);

    t = 0;
    while (!r_done && t < 10000) begin idle(1); t++; end
    check("refresh_test_done", 32'(r_done), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- refresh instance sequence and driver ----------------
  function automatic logic [23:0] rpix(input int i);
    return {8'(i * 17), 8'hA5, 8'(255 - i)};
  endfunction

  initial begin : refresh_seq
    int last, nstart, t;
    r_rst_n = 1'b0; r_wr_en = 1'b0; r_wr_addr = '0; r_wr_data = '0; r_commit = 1'b0;
    r_cnt = '0; r_bright = 8'hFF; r_busy = 1'b0; r_req = 1'b0; r_addr = '0;
    repeat (3) @(posedge clk_i);
    #1 r_rst_n = 1'b1;
    for (int i = 0; i < NL; i++) begin
      r_wr_en = 1'b1; r_wr_addr = AW'(i); r_wr_data = rpix(i);
      @(posedge clk_i); #1;
    end
    r_wr_en = 1'b0; r_commit = 1'b1;
    @(posedge clk_i); #1 r_commit = 1'b0;
    last = -1; nstart = 0; t = 0;
    while (nstart < 7 && t < 8000) begin
      @(negedge clk_i); t++;
      if (r_start) begin
        if (nstart >= 2) check("refresh_period", cyc - last, 1000);
        check("refresh_led_count", 32'(r_led_cnt), 0);
        check("refresh_pending_clear", 32'(r_pending), 0);
        last = cyc; nstart++;
        @(posedge clk_i); #1 r_busy = 1'b1;
        for (int k = 0; k < NL; k++) begin
          @(posedge clk_i); #1 r_req = 1'b1; r_addr = AW'(k);
          @(posedge clk_i); #1 r_req = 1'b0;
          @(negedge clk_i);
          check("refresh_pixel", {8'h00, r_red, r_green, r_blue}, {8'h00, rpix(k)});
        end
        @(posedge clk_i); #1 r_busy = 1'b0;
        @(negedge clk_i); check("refresh_frame_done", 32'(r_frame_done), 1);
      end
    end
    check("refresh_starts", nstart, 7);
    r_done = 1;
  end

endmodule
